cmd_str_tx: RTL and testbench



---
 rtl/cmd_str_tx.sv | 174 +++++++++++++++++
 tb/tb_cmd_str_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_str_tx.sv
// Command-string transmitter: turns a snapshotted command and BCD time into a UART byte stream.
// Optional macro CMD_TX_QUEUE_EN adds a one-entry pending-command slot.
module cmd_str_tx #(
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] cmd_type,
  input  logic [3:0] Mtens,
  input  logic [3:0] Mones,
  input  logic [3:0] Stens,
  input  logic [3:0] Sones,
  input  logic       tx_busy,
  output logic       tx_data_rdy,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_t;

  function automatic logic cmd_ok(input logic [1:0] t, input logic [15:0] d);
    case (t)
      2'd0, 2'd1: return (d[15:12] <= 4'd5) && (d[11:8] <= 4'd9) &&
                         (d[7:4] <= 4'd5) && (d[3:0] <= 4'd9);
      2'd2:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [1:0] t, input logic [15:0] d,
                                          input logic [2:0] idx);
    case (idx)
      3'd0: begin
        case (t)
          2'd0:    return 8'h6C;
          2'd1:    return 8'h61;
          2'd2:    return 8'h40;
          default: return 8'h00;
        endcase
      end
      3'd1:    return {4'h3, d[15:12]};
      3'd2:    return {4'h3, d[11:8]};
      3'd3:    return {4'h3, d[7:4]};
      3'd4:    return {4'h3, d[3:0]};
      3'd5:    return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  state_t        state_q;
  logic [1:0]    type_q;
  logic [15:0]   dig_q;
  logic [2:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic          tx_data_rdy_q, busy_q, done_q, err_q;
  logic [7:0]    tx_data_q;
`ifdef CMD_TX_QUEUE_EN
  logic          pend_valid_q;
  logic [1:0]    pend_type_q;
  logic [15:0]   pend_dig_q;
`endif

  logic [15:0] dig_in;
  logic        in_ok;
  logic        last_byte;

  assign dig_in    = {Mtens, Mones, Stens, Sones};
  assign in_ok     = cmd_ok(cmd_type, dig_in);
  assign last_byte = (type_q == 2'd2) ? 1'b1 : (idx_q == 3'd5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      type_q        <= 2'd0;
      dig_q         <= 16'h0000;
      idx_q         <= 3'd0;
      gap_q         <= '0;
      tx_data_rdy_q <= 1'b0;
      tx_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef CMD_TX_QUEUE_EN
      pend_valid_q  <= 1'b0;
      pend_type_q   <= 2'd0;
      pend_dig_q    <= 16'h0000;
`endif
    end else begin
      tx_data_rdy_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            if (in_ok) begin
              type_q  <= cmd_type;
              dig_q   <= dig_in;
              idx_q   <= 3'd0;
              busy_q  <= 1'b1;
              state_q <= ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!tx_busy) begin
            tx_data_rdy_q <= 1'b1;
            tx_data_q     <= byte_sel(type_q, dig_q, idx_q);
            gap_q         <= '0;
            // No inter-byte gap after the final byte so done follows the last strobe directly.
            state_q       <= last_byte ? FIN : GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= ISSUE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        FIN: begin
          done_q <= 1'b1;
`ifdef CMD_TX_QUEUE_EN
          if (pend_valid_q) begin
            type_q       <= pend_type_q;
            dig_q        <= pend_dig_q;
            idx_q        <= 3'd0;
            pend_valid_q <= 1'b0;
            state_q      <= ISSUE;
          end else if (go && in_ok) begin
            type_q  <= cmd_type;
            dig_q   <= dig_in;
            idx_q   <= 3'd0;
            state_q <= ISSUE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`else
          busy_q  <= 1'b0;
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
`ifdef CMD_TX_QUEUE_EN
      if (go && (state_q != IDLE)) begin
        if (!in_ok) begin
          err_q <= 1'b1;
        end else if (!pend_valid_q && (state_q != FIN)) begin
          pend_valid_q <= 1'b1;
          pend_type_q  <= cmd_type;
          pend_dig_q   <= dig_in;
        end
      end
`endif
    end
  end

  assign tx_data_rdy = tx_data_rdy_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cmd_str_tx.sv
// Directed bench for cmd_str_tx: byte order, strobe spacing, stalls, rejects, reset abort, busy go.
module tb_cmd_str_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [1:0] cmd_type = 2'd0;
  logic [3:0] Mtens = 4'd0, Mones = 4'd0, Stens = 4'd0, Sones = 4'd0;
  logic       tx_busy = 1'b0;
  logic       tx_data_rdy;
  logic [7:0] tx_data;
  logic       busy, done, err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ecnt = 0;
  logic [7:0] bq[$];
  int cq[$];
  int dq[$];

  cmd_str_tx #(.GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .go(go), .cmd_type(cmd_type),
    .Mtens(Mtens), .Mones(Mones), .Stens(Stens), .Sones(Sones),
    .tx_busy(tx_busy), .tx_data_rdy(tx_data_rdy), .tx_data(tx_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_data_rdy) begin
        bq.push_back(tx_data);
        cq.push_back(cyc);
      end
      if (done) dq.push_back(cyc);
      if (err) ecnt = ecnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    bq.delete();
    cq.delete();
    dq.delete();
    ecnt = 0;
  endtask

  task automatic do_go(input logic [1:0] t, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, output int g);
    @(negedge clk);
    cmd_type = t; Mtens = a; Mones = b; Stens = c; Sones = d;
    go = 1'b1;
    g = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int n, input int lim);
    int k = 0;
    while (dq.size() < n && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (dq.size() < n) check("wait_done_timeout", dq.size(), n);
  endtask

  task automatic wait_bytes(input int n, input int lim);
    int k = 0;
    while (bq.size() < n && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (bq.size() < n) check("wait_bytes_timeout", bq.size(), n);
  endtask

  initial begin
    int g;
    int rel;
    logic [7:0] e0 [6];
    logic [7:0] e1 [6];
    logic [7:0] eq [7];

    e0 = '{8'h6C, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
    e1 = '{8'h61, 8'h35, 8'h39, 8'h35, 8'h39, 8'h0D};
    eq = '{8'h40, 8'h6C, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_rdy", tx_data_rdy, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);

    // Type 0, 1/2/3/4, no back-pressure: strobes at go+2 then every 5 cycles.
    clear_log();
    do_go(2'd0, 4'd1, 4'd2, 4'd3, 4'd4, g);
    wait_done(1, 200);
    check("t0_nbytes", bq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < bq.size()) begin
        check($sformatf("t0_byte%0d", i), bq[i], e0[i]);
        check($sformatf("t0_cyc%0d", i), cq[i] - g, 2 + 5 * i);
      end
    end
    if (dq.size() > 0 && cq.size() == 6) check("t0_done_cyc", dq[0] - cq[5], 1);
    check("t0_busy_after", busy, 1'b0);
    check("t0_err", ecnt, 0);

    // Type 1, 5/9/5/9, tx_busy high for 20 cycles once 3 bytes are out.
    clear_log();
    do_go(2'd1, 4'd5, 4'd9, 4'd5, 4'd9, g);
    wait_bytes(3, 100);
    tx_busy = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("stall_nbytes", bq.size(), 3);
    check("stall_data", tx_data, 8'h39);
    check("stall_busy", busy, 1'b1);
    rel = cyc;
    tx_busy = 1'b0;
    wait_done(1, 200);
    check("t1_nbytes", bq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < bq.size()) check($sformatf("t1_byte%0d", i), bq[i], e1[i]);
    end
    if (cq.size() > 3) check("t1_resume_cyc", cq[3] - rel, 1);

    // Rejected commands: bad minute tens, then reserved type.
    clear_log();
    do_go(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, g);
    check("rej6_err", err, 1'b1);
    check("rej6_busy", busy, 1'b0);
    do_go(2'd3, 4'd0, 4'd0, 4'd0, 4'd0, g);
    check("rej3_err", err, 1'b1);
    check("rej3_busy", busy, 1'b0);
    do_go(2'd1, 4'd0, 4'd0, 4'd0, 4'hA, g);
    check("rejA_err", err, 1'b1);
    repeat (10) @(negedge clk);
    check("rej_nbytes", bq.size(), 0);
    check("rej_errcnt", ecnt, 3);

    // Arm toggle: single '@' strobe, done next cycle.
    clear_log();
    do_go(2'd2, 4'd0, 4'd0, 4'd0, 4'd0, g);
    wait_done(1, 50);
    check("t2_nbytes", bq.size(), 1);
    if (bq.size() > 0) check("t2_byte", bq[0], 8'h40);
    if (bq.size() > 0 && dq.size() > 0) check("t2_done_cyc", dq[0] - cq[0], 1);

    // Reset after the second byte of a type-0 command.
    clear_log();
    do_go(2'd0, 4'd1, 4'd2, 4'd3, 4'd4, g);
    wait_bytes(2, 100);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_data", tx_data, 8'h00);
    check("arst_rdy", tx_data_rdy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_nbytes", bq.size(), 2);
    check("arst_ndone", dq.size(), 0);

`ifdef CMD_TX_QUEUE_EN
    // Pending slot: arm toggle, queued type 0, third go dropped.
    clear_log();
    do_go(2'd2, 4'd0, 4'd0, 4'd0, 4'd0, g);
    do_go(2'd0, 4'd0, 4'd0, 4'd0, 4'd7, g);
    do_go(2'd1, 4'd1, 4'd1, 4'd1, 4'd1, g);
    wait_done(2, 200);
    repeat (40) @(negedge clk);
    check("q_nbytes", bq.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < bq.size()) check($sformatf("q_byte%0d", i), bq[i], eq[i]);
    end
    check("q_ndone", dq.size(), 2);
    check("q_err", ecnt, 0);
    check("q_busy", busy, 1'b0);
`else
    // Without a slot, a go while busy is ignored without err.
    clear_log();
    do_go(2'd2, 4'd0, 4'd0, 4'd0, 4'd0, g);
    do_go(2'd0, 4'd0, 4'd0, 4'd0, 4'd7, g);
    repeat (60) @(negedge clk);
    check("nq_nbytes", bq.size(), 1);
    if (bq.size() > 0) check("nq_byte", bq[0], eq[0]);
    check("nq_ndone", dq.size(), 1);
    check("nq_err", ecnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
